// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM with
// press/release qualification, and a long-press hold counter.
// All outputs are registered; strobes are single-cycle and mutually exclusive.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int W            = 20,
  parameter int LONG_CYC     = 100_000_000,
  parameter int LW           = 27
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [W-1:0]  CNT_LAST  = W'(DEBOUNCE_CYC - 1);
  localparam logic [W-1:0]  CNT_ONE   = W'(1);
  localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYC);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] HOLD_ONE  = LW'(1);

  logic          sync1_q, sync2_q;
  logic          btn_s;
  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  assign btn_s = sync2_q;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: qualify changes of btn_s and track press duration
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          // bounce rejected, back to idle without a strobe
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (hold_q < HOLD_MAX) begin
          // saturating hold count; the long strobe marks reaching the limit
          hold_d = hold_q + HOLD_ONE;
          if (hold_q == HOLD_LAST) begin
            long_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // release glitch: keep hold so btn_long cannot fire twice
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
          hold_d    = '0;
          cnt_d     = '0;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios followed by random button
// activity, every cycle compared against a run-length behavioural model.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst_btn = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long;

  btn_debounce #(.DEBOUNCE_CYC(DEB), .W(4), .LONG_CYC(LONG), .LW(5)) dut (
    .clk        (clk),
    .rst_btn    (rst_btn),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #4 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // reference model: synchroniser delay line, accepted level, length of the
  // current run of samples disagreeing with it, and cycles held while pressed
  logic m_s1, m_s2, m_level;
  int   m_run, m_hold;
  logic e_press, e_rel, e_long;

  int edge_n = 0;
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int last_press = -1, last_long = -1, last_rel = -1;
  int e0, pc0, rc0, lc0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
    m_run = 0; m_hold = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  // one clock edge: advance the model with the input seen at the edge, then check
  task automatic step();
    logic b, s;
    b = btn_in;
    @(posedge clk);
    edge_n++;
    if (rst_btn) begin
      model_reset();
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = s;
          m_run = 0;
          m_hold = 0;
          if (s) e_press = 1'b1;
          else   e_rel = 1'b1;
        end
      end else begin
        // a sample agreeing with a pressed level counts toward the hold,
        // except the one that ends an aborted release attempt
        if (m_level && m_run == 0 && m_hold < LONG) begin
          m_hold++;
          if (m_hold == LONG) e_long = 1'b1;
        end
        m_run = 0;
      end
    end
    #1;
    if (btn_press)   begin press_cnt++; last_press = edge_n; end
    if (btn_release) begin rel_cnt++;   last_rel = edge_n;   end
    if (btn_long)    begin long_cnt++;  last_long = edge_n;  end
    chk1("level", btn_level, m_level);
    chk1("press", btn_press, e_press);
    chk1("release", btn_release, e_rel);
    chk1("long", btn_long, e_long);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_btn = 1'b1;
    #1;
    model_reset();
    chk1("rst_imm_level", btn_level, 1'b0);
    chk1("rst_imm_press", btn_press, 1'b0);
    chk1("rst_imm_release", btn_release, 1'b0);
    chk1("rst_imm_long", btn_long, 1'b0);
    steps(cycles);
    rst_btn = 1'b0;
  endtask

  initial begin
    int len;
    model_reset();

    // 1: reset for ~100 ns, then idle for 200 ns with no strobes
    steps(12);
    rst_btn = 1'b0;
    pc0 = press_cnt; rc0 = rel_cnt; lc0 = long_cnt;
    steps(25);
    chkn("t1_no_strobe", press_cnt + rel_cnt + long_cnt, pc0 + rc0 + lc0);

    // 2: clean press held 400 ns; latency, one-cycle strobe, long press
    btn_in = 1'b1;
    e0 = edge_n; pc0 = press_cnt; lc0 = long_cnt;
    steps(50);
    chkn("t2_press_lat", last_press - e0, DEB + 2);
    chkn("t2_press_once", press_cnt - pc0, 1);
    chkn("t2_long_once", long_cnt - lc0, 1);
    chkn("t2_long_delay", last_long - last_press, LONG);
    // glitch after long fired: no release, no second long
    btn_in = 1'b0; steps(2);
    btn_in = 1'b1; steps(10);
    chkn("t2_glitch_long", long_cnt - lc0, 1);
    chk1("t2_glitch_level", btn_level, 1'b1);
    btn_in = 1'b0;
    rc0 = rel_cnt;
    steps(10);
    chkn("t2_release", rel_cnt - rc0, 1);

    // 3: bounce every 16 ns for 80 ns, then settle high
    pc0 = press_cnt; lc0 = long_cnt; rc0 = rel_cnt;
    for (int k = 0; k < 5; k++) begin
      btn_in = (k % 2 == 0);
      if (k == 4) e0 = edge_n;
      steps(2);
    end
    steps(7);
    chkn("t3_one_press", press_cnt - pc0, 1);
    chkn("t3_press_lat", last_press - e0, DEB + 2);

    // 4: 16 ns release glitch while pressed
    btn_in = 1'b0; steps(2);
    btn_in = 1'b1; steps(4);
    chk1("t4_level", btn_level, 1'b1);
    chkn("t4_no_release", rel_cnt - rc0, 0);

    // 5: clean release before the long-press time
    btn_in = 1'b0;
    e0 = edge_n;
    steps(10);
    chkn("t5_rel_lat", last_rel - e0, DEB + 2);
    chkn("t5_one_release", rel_cnt - rc0, 1);
    chkn("t5_no_long", long_cnt - lc0, 0);

    // 6: reset during PRESS_WAIT with button held, re-qualified as a new press
    btn_in = 1'b1;
    steps(4);
    pc0 = press_cnt;
    do_reset(2);
    e0 = edge_n;
    steps(10);
    chkn("t6_press_lat", last_press - e0, DEB + 2);
    chkn("t6_one_press", press_cnt - pc0, 1);
    // reset while pressed clears the level immediately
    chk1("t6_pressed_before", btn_level, 1'b1);
    do_reset(1);
    btn_in = 1'b0;
    steps(10);

    // random button activity, including long holds and a mid-run reset
    for (int seg = 0; seg < 40; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(25, 35));
      else len = int'($urandom_range(1, 6));
      steps(len);
      if (seg == 20) do_reset(int'($urandom_range(1, 3)));
    end
    btn_in = 1'b0;
    steps(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
